fsm_sequencer: RTL and testbench
================================

FSM_SEQUENCER -- requirements
Module: fsm_sequencer

Interface
REQ-001 Parameter: WD_MAX, 1024, number of WAIT-state cycles without READY before FAULT; SHALL be greater than the linked timer length N.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: READY  input  1  done flag from the downstream linked timer.
REQ-005 Port: REQ  input  1  service request; any width pulse.
REQ-006 Port: START  output  1  launch pulse to the timer's START input.
REQ-007 Port: T_RESET  output  1  release strobe to the timer's RESET input.
REQ-008 Port: LIGHT  output  3  lamp drive {R,A,G}.
REQ-009 Port: PHASE  output  2  current phase index.
REQ-010 Port: FAULT  output  1  watchdog fault flag.

Function
REQ-011 SHALL be a Moore FSM with states IDLE, LAUNCH, WAIT, RELEASE and FAULT; all outputs decode from registered state, phase and READY only.
REQ-012 Phase encoding SHALL be: 0 RED (LIGHT=100), 1 RED_AMBER (110), 2 GREEN (001), 3 AMBER (010); PHASE equals the phase register.
REQ-013 A request latch SHALL set on any cycle with REQ=1 and clear on the IDLE->LAUNCH transition; clear wins over a simultaneous set.
REQ-014 IDLE: phase held at 0; T_RESET=READY (flushes a stale timer); go to LAUNCH with phase<=1 when (REQ or latch)=1 and READY=0; otherwise stay.
REQ-015 LAUNCH: START=1 for exactly one cycle; watchdog count cleared; go to WAIT unconditionally.
REQ-016 WAIT: START=0, T_RESET=0; READY=1 -> RELEASE; else increment watchdog; when watchdog reaches WD_MAX-1 with READY=0 -> FAULT.
REQ-017 RELEASE: T_RESET=1 for exactly one cycle; if phase=0 -> IDLE, phase stays 0; else phase<=(phase+1) mod 4 and -> LAUNCH.
REQ-018 Full sequence per request SHALL be phases 1,2,3,0 (each timed by one timer run), then IDLE in RED.
REQ-019 Latency: REQ high in cycle k while in IDLE with READY=0 -> START high in cycle k+1.
REQ-020 With a timer of length N, START-to-START interval SHALL be N+1 cycles; a full request cycle is 4(N+1) cycles from first START to IDLE.
REQ-021 READY=1 in LAUNCH or RELEASE SHALL NOT alter the transitions.
REQ-022 FAULT: LIGHT=010, FAULT=1, T_RESET=1, START=0; state SHALL remain FAULT until RESET.
REQ-023 REQ pulses arriving outside IDLE SHALL be held by the latch and serviced on the first IDLE cycle with READY=0.
REQ-024 The watchdog counter SHALL be wide enough to hold WD_MAX-1 without wrap.

Reset
REQ-025 RESET=1 at a rising edge SHALL force state IDLE, phase 0, latch 0 and watchdog 0, regardless of current state, including FAULT and mid-phase.
REQ-026 Output values in the cycle after reset: START=0, LIGHT=100, PHASE=0, FAULT=0, T_RESET=READY.
REQ-027 RESET SHALL NOT drive the timer; a timer left mid-count or parked at READY is recovered by the IDLE flush (REQ-014).

Verification (linked to a timer with N=4, WD_MAX=16)
REQ-028 Reset held 2 cycles -> LIGHT=100, PHASE=0, START=0, T_RESET=0, FAULT=0.
REQ-029 REQ pulsed 1 cycle at k -> START at k+1, k+6, k+11, k+16; LIGHT 110, 001, 010, 100 for 5 cycles each; IDLE at k+21; exactly 4 T_RESET pulses.
REQ-030 REQ pulsed during GREEN -> no effect until IDLE is reached; the next cycle shows START=1 and PHASE=1.
REQ-031 READY tied 0 after START -> FAULT=1 and LIGHT=010 after 16 WAIT cycles; stays in FAULT despite REQ; RESET returns LIGHT=100.
REQ-032 READY=1 in IDLE with REQ=1 -> T_RESET=1, START=0; START follows one cycle after READY falls.
REQ-033 RESET during GREEN -> next cycle IDLE, LIGHT=100, PHASE=0, latch cleared, no START without a new REQ.

Source files
------------

// File: rtl/fsm_sequencer_if.sv
// ---------------------------------------------------------------------------
// fsm_sequencer_if
//   Groups the lamp-sequencer handshake with its linked timer and the lamp
//   and status outputs.
//
//   READY    timer done flag            (timer -> sequencer)
//   REQ      service request, any width (requester -> sequencer)
//   START    one-cycle timer launch     (sequencer -> timer)
//   T_RESET  timer release/flush strobe (sequencer -> timer)
//   LIGHT    lamp drive {R,A,G}
//   PHASE    current phase index
//   FAULT    watchdog fault flag
//
//   slave  : the sequencer's view
//   master : the environment's view (requester + timer + lamp driver)
// ---------------------------------------------------------------------------
interface fsm_sequencer_if;
    logic       READY;
    logic       REQ;
    logic       START;
    logic       T_RESET;
    logic [2:0] LIGHT;
    logic [1:0] PHASE;
    logic       FAULT;

    modport slave (
        input  READY, REQ,
        output START, T_RESET, LIGHT, PHASE, FAULT
    );

    modport master (
        output READY, REQ,
        input  START, T_RESET, LIGHT, PHASE, FAULT
    );
endinterface

// File: rtl/fsm_sequencer.sv
// ---------------------------------------------------------------------------
// fsm_sequencer
//   Moore FSM that walks a traffic lamp through RED_AMBER, GREEN, AMBER and
//   back to RED for every service request. Each phase is timed by one run of
//   an external linked timer: the sequencer pulses START, waits for READY,
//   then pulses T_RESET to release the timer. A watchdog traps a timer that
//   never answers and parks the lamp at AMBER with FAULT raised until RESET.
//
//   Ports
//     CLK    single clock, rising edge
//     RESET  synchronous, active-high
//     bus    fsm_sequencer_if.slave (READY, REQ in; START, T_RESET, LIGHT,
//            PHASE, FAULT out)
//
//   Parameter
//     WD_MAX  WAIT cycles without READY before FAULT; must exceed the timer
//             length and be at least 2.
// ---------------------------------------------------------------------------
module fsm_sequencer #(
    parameter int WD_MAX = 1024
) (
    input  logic           CLK,
    input  logic           RESET,
    fsm_sequencer_if.slave bus
);

    // Counter holds 0 .. WD_MAX-1 without wrapping.
    localparam int                WD_W    = $clog2(WD_MAX);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WD_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RELEASE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        PH_RED       = 2'd0,
        PH_RED_AMBER = 2'd1,
        PH_GREEN     = 2'd2,
        PH_AMBER     = 2'd3
    } phase_t;

    state_t          state;
    phase_t          phase;
    logic            req_latch;
    logic [WD_W-1:0] wd_cnt;

    function automatic logic [2:0] lamp(input phase_t ph);
        case (ph)
            PH_RED:       lamp = 3'b100;
            PH_RED_AMBER: lamp = 3'b110;
            PH_GREEN:     lamp = 3'b001;
            default:      lamp = 3'b010;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State, phase, request latch and watchdog
    // -----------------------------------------------------------------------
    // NOTE: all state uses non-blocking assignments; later assignments in the
    // same clock override earlier ones, which gives "clear wins over set"
    // for the request latch on the IDLE->LAUNCH transition.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            phase     <= PH_RED;
            req_latch <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            // Requests arriving while busy (or in FAULT) are remembered here.
            if (bus.REQ) begin
                req_latch <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    phase <= PH_RED;
                    // A timer still showing READY is being flushed by
                    // T_RESET this cycle; launch only once it has dropped.
                    if ((bus.REQ || req_latch) && !bus.READY) begin
                        state     <= S_LAUNCH;
                        phase     <= PH_RED_AMBER;
                        req_latch <= 1'b0;
                    end
                end

                S_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.READY) begin
                        state <= S_RELEASE;
                    end else if (wd_cnt == WD_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                S_RELEASE: begin
                    // RED is the last timed phase of a request.
                    if (phase == PH_RED) begin
                        state <= S_IDLE;
                    end else begin
                        phase <= phase_t'(phase + 2'd1);
                        state <= S_LAUNCH;
                    end
                end

                S_FAULT: begin
                    state <= S_FAULT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Moore output decode from registered state/phase plus READY
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        bus.START   = 1'b0;
        bus.T_RESET = 1'b0;
        bus.FAULT   = 1'b0;
        bus.LIGHT   = lamp(phase);
        case (state)
            S_IDLE:    bus.T_RESET = bus.READY;
            S_LAUNCH:  bus.START   = 1'b1;
            S_RELEASE: bus.T_RESET = 1'b1;
            S_FAULT: begin
                bus.FAULT   = 1'b1;
                // Hold the timer in reset while faulted.
                bus.T_RESET = 1'b1;
                bus.LIGHT   = 3'b010;
            end
            default: begin
            end
        endcase
    end

    assign bus.PHASE = phase;

endmodule

// File: tb/tb_fsm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fsm_sequencer
//   Bench for fsm_sequencer linked to a behavioural timer of length N=4,
//   WD_MAX=16. Random REQ traffic is scored against a schedule model: an
//   accepted request occupies 4*(N+1) cycles starting the cycle after it is
//   accepted, split into phases 1,2,3,0 of N+1 cycles each. Directed
//   sections cover the stale-READY flush, watchdog fault and reset mid-phase.
// ---------------------------------------------------------------------------
module tb_fsm_sequencer;

    localparam int N       = 4;
    localparam int WD      = 16;
    localparam int SEG     = N + 1;
    localparam int SEQ_LEN = 4 * SEG;

    logic CLK = 1'b0;
    logic RESET;

    fsm_sequencer_if bus ();

    fsm_sequencer #(.WD_MAX(WD)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- linked timer model (length N) ----------------
    bit          t_run = 1'b0;
    int unsigned t_cnt = 0;
    logic        tim_ready;
    logic        ovr_en  = 1'b0;
    logic        ovr_val = 1'b0;

    always @(posedge CLK) begin
        if (bus.T_RESET === 1'b1) begin
            t_run <= 1'b0;
            t_cnt <= 0;
        end else if (bus.START === 1'b1) begin
            t_run <= 1'b1;
            t_cnt <= 1;
        end else if (t_run && t_cnt < N - 1) begin
            t_cnt <= t_cnt + 1;
        end
    end

    assign tim_ready = t_run && (t_cnt >= N - 1);
    assign bus.READY = ovr_en ? ovr_val : tim_ready;

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] lamp_of(input logic [1:0] ph);
        logic [2:0] tbl [4];
        tbl[0] = 3'b100;
        tbl[1] = 3'b110;
        tbl[2] = 3'b001;
        tbl[3] = 3'b010;
        return tbl[ph];
    endfunction

    typedef struct {
        int         cyc;
        logic       start;
        logic [2:0] light;
        logic [1:0] phase;
        logic       trel;
        logic       idle;
    } exp_t;

    exp_t sb[$];

    // Expected outputs for cycle t given a request schedule starting at s.
    function automatic exp_t predict(input int t, input bit busy, input int s);
        exp_t e;
        int   off;
        e.cyc   = t;
        e.start = 1'b0;
        e.trel  = 1'b0;
        e.idle  = 1'b1;
        e.phase = 2'd0;
        if (busy && t >= s && t < s + SEQ_LEN) begin
            off     = t - s;
            e.idle  = 1'b0;
            e.phase = 2'((off / SEG + 1) % 4);
            e.start = (off % SEG) == 0;
            e.trel  = (off % SEG) == N;
        end
        e.light = lamp_of(e.phase);
        return e;
    endfunction

    // Reference model: decides acceptance of requests and pushes the
    // expectation for the following cycle.
    bit model_en = 1'b0;
    bit m_busy   = 1'b0;
    bit m_pend   = 1'b0;
    int m_s      = 0;

    initial begin
        forever begin
            bit idle_now;
            @(negedge CLK);
            if (model_en) begin
                idle_now = !(m_busy && cyc < m_s + SEQ_LEN);
                if (idle_now && (bus.REQ || m_pend) && !bus.READY) begin
                    m_s    = cyc + 1;
                    m_busy = 1'b1;
                    m_pend = 1'b0;
                end else if (bus.REQ) begin
                    m_pend = 1'b1;
                end
                sb.push_back(predict(cyc + 1, m_busy, m_s));
            end
        end
    end

    // Monitor: compares DUT outputs whenever an expectation for this cycle
    // is waiting in the scoreboard.
    initial begin
        forever begin
            exp_t e;
            @(negedge CLK);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("sb_start", 32'(bus.START), 32'(e.start));
                check("sb_light", 32'(bus.LIGHT), 32'(e.light));
                check("sb_phase", 32'(bus.PHASE), 32'(e.phase));
                check("sb_t_reset", 32'(bus.T_RESET),
                      32'(e.trel | (e.idle & bus.READY)));
                check("sb_fault", 32'(bus.FAULT), 32'd0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        int n_start;

        RESET   = 1'b1;
        bus.REQ = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_light",   32'(bus.LIGHT),   32'b100);
        check("rst_phase",   32'(bus.PHASE),   32'd0);
        check("rst_start",   32'(bus.START),   32'd0);
        check("rst_t_reset", 32'(bus.T_RESET), 32'd0);
        check("rst_fault",   32'(bus.FAULT),   32'd0);

        // Random request traffic, including pulses mid-sequence.
        next_cycle();
        model_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            bus.REQ = ($urandom_range(0, 39) == 0) ||
                      (bus.REQ && $urandom_range(0, 1) == 1);
            next_cycle();
        end
        bus.REQ = 1'b0;
        repeat (2 * SEQ_LEN + 5) next_cycle();
        model_en = 1'b0;
        repeat (2) @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Stale READY in IDLE: flush, no launch until READY falls.
        next_cycle();
        ovr_en  = 1'b1;
        ovr_val = 1'b1;
        bus.REQ = 1'b1;
        @(negedge CLK);
        check("stale_t_reset", 32'(bus.T_RESET), 32'd1);
        check("stale_start",   32'(bus.START),   32'd0);
        next_cycle();
        bus.REQ = 1'b0;
        @(negedge CLK);
        check("stale_hold_start", 32'(bus.START), 32'd0);
        next_cycle();
        ovr_val = 1'b0;
        @(negedge CLK);
        check("stale_fall_start",   32'(bus.START),   32'd0);
        check("stale_fall_t_reset", 32'(bus.T_RESET), 32'd0);
        next_cycle();
        ovr_en = 1'b0;
        @(negedge CLK);
        check("stale_launch_start", 32'(bus.START), 32'd1);
        check("stale_launch_phase", 32'(bus.PHASE), 32'd1);
        check("stale_launch_light", 32'(bus.LIGHT), 32'b110);
        repeat (SEQ_LEN + 2) next_cycle();
        @(negedge CLK);
        check("stale_end_light", 32'(bus.LIGHT), 32'b100);
        check("stale_end_phase", 32'(bus.PHASE), 32'd0);

        // Watchdog: timer never answers.
        next_cycle();
        bus.REQ = 1'b1;
        next_cycle();
        bus.REQ = 1'b0;
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        @(negedge CLK);
        check("wd_launch_start", 32'(bus.START), 32'd1);
        repeat (WD) next_cycle();
        @(negedge CLK);
        check("wd_last_wait_fault", 32'(bus.FAULT), 32'd0);
        next_cycle();
        @(negedge CLK);
        check("wd_fault",   32'(bus.FAULT),   32'd1);
        check("wd_light",   32'(bus.LIGHT),   32'b010);
        check("wd_t_reset", 32'(bus.T_RESET), 32'd1);
        check("wd_start",   32'(bus.START),   32'd0);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            bus.REQ = (i < 2);
            @(negedge CLK);
            check("wd_stuck_fault", 32'(bus.FAULT), 32'd1);
            check("wd_stuck_start", 32'(bus.START), 32'd0);
        end
        next_cycle();
        RESET   = 1'b1;
        bus.REQ = 1'b0;
        ovr_en  = 1'b0;
        next_cycle();
        RESET = 1'b0;
        @(negedge CLK);
        check("wd_rst_light", 32'(bus.LIGHT), 32'b100);
        check("wd_rst_fault", 32'(bus.FAULT), 32'd0);
        check("wd_rst_phase", 32'(bus.PHASE), 32'd0);
        check("wd_rst_start", 32'(bus.START), 32'd0);
        next_cycle();
        @(negedge CLK);
        check("wd_rst_no_relaunch", 32'(bus.START), 32'd0);

        // Reset during GREEN with the timer mid-count.
        next_cycle();
        bus.REQ = 1'b1;
        next_cycle();
        bus.REQ = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * SEQ_LEN && !found; i++) begin
            @(negedge CLK);
            if (bus.PHASE == 2'd2) found = 1'b1;
        end
        check("green_reached", 32'(found), 32'd1);
        repeat (2) next_cycle();
        RESET = 1'b1;
        next_cycle();
        RESET = 1'b0;
        @(negedge CLK);
        check("gr_rst_light", 32'(bus.LIGHT), 32'b100);
        check("gr_rst_phase", 32'(bus.PHASE), 32'd0);
        check("gr_rst_start", 32'(bus.START), 32'd0);
        n_start = 0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            next_cycle();
            @(negedge CLK);
            if (bus.START === 1'b1) n_start++;
            check("gr_flush_t_reset", 32'(bus.T_RESET), 32'(bus.READY));
        end
        check("gr_no_start", 32'(n_start), 32'd0);
        check("gr_idle_light", 32'(bus.LIGHT), 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
